frame_timing_gen: RTL and testbench
===================================

# frame_timing_gen

Frame/line timing sequencer for the test-pattern datapath. Generates the `f_sync`, `sync`, `endLine` and `endFrame` strobes that drive the pattern control FSM and counters. Latches pattern mode and ramp deltaX once per frame so they are stable across the frame. Supports single-frame and continuous runs, and stops only on a frame boundary.

## Interface
- `H_ACTIVE`, default 64: active pixels per line (1..4095).
- `H_BLANK`, default 8: horizontal blanking cycles per line (>=1).
- `V_ACTIVE`, default 32: active lines per frame (1..4095).
- `V_BLANK`, default 2: vertical blanking lines per frame (>=1).
- `clk`  in  1  master clock. One clock domain; all logic on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  run request; sampled only in IDLE.
- `stop`  in  1  stop request; sets `stop_pending`, which is honoured at end of frame.
- `cont`  in  1  sampled with `start`: 1 = continuous frames, 0 = single frame.
- `mode_in`  in  3  requested pattern mode (1..7; 0 is invalid).
- `x_in`  in  2  requested ramp deltaX code.
- `f_sync`  out  1  first-line sync pulse, 1 cycle, line 0 only.
- `sync`  out  1  line-start pulse, 1 cycle, every active line.
- `endLine`  out  1  high while not in active pixels (HBLANK, VBLANK).
- `endFrame`  out  1  high during VBLANK.
- `Mode`  out  3  latched mode, constant for the whole frame.
- `X`  out  2  latched deltaX, constant for the whole frame.
- `pix_cnt`  out  12  active pixel index; 0 outside ACTIVE.
- `line_cnt`  out  12  active line index; holds V_ACTIVE-1 during VBLANK.
- `frame_cnt`  out  8  completed frames, wraps 255->0.
- `busy`  out  1  high in any state except IDLE.
- `cfg_err`  out  1  1-cycle pulse when `start` is rejected because `mode_in`==0.

## Operation
- All outputs are registered. Every output is 0 in reset and in IDLE, except `frame_cnt`, which holds its value in IDLE and is 0 only after reset.
- Line period L = 1 + H_ACTIVE + H_BLANK. Frame period = (V_ACTIVE + V_BLANK) * L.
- States:
  - **IDLE.** `start`=1 and `mode_in`!=0: latch `Mode`, `X` and `cont`; clear `stop_pending`, then set it if `stop`=1 or `cont`=0; go to SYNC with row 0. `start`=1 and `mode_in`==0: pulse `cfg_err` and stay in IDLE.
  - **SYNC.** 1 cycle. `sync`=1; `f_sync`=1 if row==0. Then go to ACTIVE.
  - **ACTIVE.** H_ACTIVE cycles. `pix_cnt` runs 0..H_ACTIVE-1 and `endLine`=0. Then go to HBLANK.
  - **HBLANK.** H_BLANK cycles with `endLine`=1. At the end: if row<V_ACTIVE-1, increment row and go to SYNC; otherwise go to VBLANK.
  - **VBLANK.** V_BLANK*L cycles with `endLine`=1 and `endFrame`=1. At the end, increment `frame_cnt`. Then: if `stop_pending`, go to IDLE; otherwise relatch `Mode` and `X` from the inputs, set row=0 and go to SYNC.
- `stop` may be asserted at any time while busy. It is never lost and never truncates a frame.
- `start` while busy is ignored.
- `mode_in` and `x_in` changes take effect only at a frame boundary; they have no effect mid-frame.

## Timing
- `start` is sampled on edge n; `busy`, `sync` and `f_sync` are high in cycle n+1.
- `f_sync`/`sync` lead the first `pix_cnt`=0 cycle by exactly 1 cycle.
- `endLine` rises the cycle after `pix_cnt`=H_ACTIVE-1.
- `endFrame` rises the cycle after the last HBLANK cycle of line V_ACTIVE-1.
- In continuous mode the next `f_sync` is in the cycle right after the last VBLANK cycle; there is no gap cycle.
- On the last VBLANK cycle with `stop_pending`, `busy` falls on the next cycle.
- `stop` on the same edge as the transition out of VBLANK: the transition decision uses `stop_pending` including this `stop`, so the block goes to IDLE.
- Async reset mid-frame forces IDLE and zero outputs immediately, without waiting for a clock edge. The first `start` after reset behaves as from power-up.

## Test plan
All scenarios use H_ACTIVE=4, H_BLANK=2, V_ACTIVE=3, V_BLANK=1, giving L=7 and a 28-cycle frame.
- **Single frame.** `start`=1, `cont`=0, `mode_in`=3 at edge 0.
  - `sync` pulses in cycles 1, 8 and 15; `f_sync` only in cycle 1; `pix_cnt` runs 0..3 in cycles 2-5.
  - `endFrame` is high in cycles 22-28; `busy` falls in cycle 29; `frame_cnt`=1; `Mode`=3 throughout the frame.
- **Continuous with mid-frame stop.** `cont`=1, `mode_in`=7, `x_in`=2; change `mode_in` to 2 at cycle 10; pulse `stop` at cycle 40.
  - Frame 1 shows `Mode`=7. Frame 2 starts with `f_sync` in cycle 29 and `Mode`=2.
  - `busy` falls in cycle 57; `frame_cnt`=2.
- **Invalid mode.** `start` with `mode_in`=0 -> `cfg_err` pulses in cycle 1; `busy` stays 0 and all strobes stay 0.
- **Start while busy.** Pulse `start` at cycle 12 during a single frame -> no effect; the frame ends at cycle 28 with `frame_cnt`=1.
- **Reset mid-frame.** Drop `rst_n` at cycle 17 -> all outputs are 0 immediately.
  - Release, then `start` -> `f_sync` appears 1 cycle after the `start` edge.
- **Stop at boundary and counter wrap.** `stop` on the last VBLANK cycle (cycle 28) in continuous mode -> IDLE in cycle 29 with no further `f_sync`. Separately, run 256 frames continuously -> `frame_cnt` wraps to 0.

Source files
------------

// File: rtl/frame_timing_gen.sv
// Frame/line timing sequencer: SYNC/ACTIVE/HBLANK per line, VBLANK per frame,
// with per-frame latching of pattern mode and deltaX and frame-boundary stop.
module frame_timing_gen #(
  parameter int unsigned H_ACTIVE = 64,
  parameter int unsigned H_BLANK  = 8,
  parameter int unsigned V_ACTIVE = 32,
  parameter int unsigned V_BLANK  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic        cont,
  input  logic [2:0]  mode_in,
  input  logic [1:0]  x_in,
  output logic        f_sync,
  output logic        sync,
  output logic        endLine,
  output logic        endFrame,
  output logic [2:0]  Mode,
  output logic [1:0]  X,
  output logic [11:0] pix_cnt,
  output logic [11:0] line_cnt,
  output logic [7:0]  frame_cnt,
  output logic        busy,
  output logic        cfg_err
);

  localparam int unsigned LINE_LEN = 1 + H_ACTIVE + H_BLANK;
  localparam int unsigned VB_LEN   = V_BLANK * LINE_LEN;
  // VBLANK is the longest phase, so it sizes the shared phase counter
  localparam int unsigned CW       = $clog2(VB_LEN + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SYNC   = 3'd1;
  localparam logic [2:0] S_ACTIVE = 3'd2;
  localparam logic [2:0] S_HBLANK = 3'd3;
  localparam logic [2:0] S_VBLANK = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [11:0]   row_q, row_d;
  logic          stop_pend_q, stop_pend_d;
  logic [2:0]    mode_q, mode_d;
  logic [1:0]    x_q, x_d;
  logic [7:0]    fcnt_q, fcnt_d;
  logic          cfg_err_q, cfg_err_d;
  logic          sync_q, sync_d;
  logic          f_sync_q, f_sync_d;
  logic          end_line_q, end_line_d;
  logic          end_frame_q, end_frame_d;
  logic [11:0]   pix_q, pix_d;
  logic [11:0]   line_q, line_d;
  logic          busy_q, busy_d;

  // Next state, then registered outputs decoded from the next state
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    row_d       = row_q;
    stop_pend_d = stop_pend_q;
    mode_d      = mode_q;
    x_d         = x_q;
    fcnt_d      = fcnt_q;
    cfg_err_d   = 1'b0;

    // a stop arriving on the frame's last edge must still be honoured
    if (state_q != S_IDLE) stop_pend_d = stop_pend_q | stop;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (mode_in != 3'd0) begin
            state_d     = S_SYNC;
            cnt_d       = '0;
            row_d       = '0;
            mode_d      = mode_in;
            x_d         = x_in;
            stop_pend_d = stop | ~cont;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      S_SYNC: begin
        state_d = S_ACTIVE;
        cnt_d   = '0;
      end
      S_ACTIVE: begin
        if (cnt_q == CW'(H_ACTIVE - 1)) begin
          state_d = S_HBLANK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_HBLANK: begin
        if (cnt_q == CW'(H_BLANK - 1)) begin
          cnt_d = '0;
          if (row_q == 12'(V_ACTIVE - 1)) begin
            state_d = S_VBLANK;
          end else begin
            state_d = S_SYNC;
            row_d   = row_q + 12'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_VBLANK: begin
        if (cnt_q == CW'(VB_LEN - 1)) begin
          fcnt_d = fcnt_q + 8'd1;
          cnt_d  = '0;
          row_d  = '0;
          if (stop_pend_d) begin
            state_d     = S_IDLE;
            stop_pend_d = 1'b0;
            mode_d      = '0;
            x_d         = '0;
          end else begin
            state_d = S_SYNC;
            mode_d  = mode_in;
            x_d     = x_in;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        row_d   = '0;
        mode_d  = '0;
        x_d     = '0;
      end
    endcase

    sync_d      = (state_d == S_SYNC);
    f_sync_d    = (state_d == S_SYNC) && (row_d == 12'd0);
    end_line_d  = (state_d == S_HBLANK) || (state_d == S_VBLANK);
    end_frame_d = (state_d == S_VBLANK);
    pix_d       = (state_d == S_ACTIVE) ? 12'(cnt_d) : 12'd0;
    line_d      = (state_d == S_IDLE) ? 12'd0 : row_d;
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      row_q       <= '0;
      stop_pend_q <= 1'b0;
      mode_q      <= '0;
      x_q         <= '0;
      fcnt_q      <= '0;
      cfg_err_q   <= 1'b0;
      sync_q      <= 1'b0;
      f_sync_q    <= 1'b0;
      end_line_q  <= 1'b0;
      end_frame_q <= 1'b0;
      pix_q       <= '0;
      line_q      <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      row_q       <= row_d;
      stop_pend_q <= stop_pend_d;
      mode_q      <= mode_d;
      x_q         <= x_d;
      fcnt_q      <= fcnt_d;
      cfg_err_q   <= cfg_err_d;
      sync_q      <= sync_d;
      f_sync_q    <= f_sync_d;
      end_line_q  <= end_line_d;
      end_frame_q <= end_frame_d;
      pix_q       <= pix_d;
      line_q      <= line_d;
      busy_q      <= busy_d;
    end
  end

  assign f_sync    = f_sync_q;
  assign sync      = sync_q;
  assign endLine   = end_line_q;
  assign endFrame  = end_frame_q;
  assign Mode      = mode_q;
  assign X         = x_q;
  assign pix_cnt   = pix_q;
  assign line_cnt  = line_q;
  assign frame_cnt = fcnt_q;
  assign busy      = busy_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_frame_timing_gen.sv
// Bench for frame_timing_gen: position-in-frame reference model checked every
// cycle, directed scenarios with literal expectations, then random stimulus.
module tb_frame_timing_gen;

  localparam int HA = 4;
  localparam int HB = 2;
  localparam int VA = 3;
  localparam int VB = 1;
  localparam int LL = 1 + HA + HB;
  localparam int FR = (VA + VB) * LL;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        cont = 1'b0;
  logic [2:0]  mode_in = 3'd0;
  logic [1:0]  x_in = 2'd0;
  logic        f_sync, sync, endLine, endFrame, busy, cfg_err;
  logic [2:0]  Mode;
  logic [1:0]  X;
  logic [11:0] pix_cnt, line_cnt;
  logic [7:0]  frame_cnt;

  int n_checks = 0;
  int n_errors = 0;

  frame_timing_gen #(.H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .V_BLANK(VB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .cont(cont),
    .mode_in(mode_in), .x_in(x_in), .f_sync(f_sync), .sync(sync),
    .endLine(endLine), .endFrame(endFrame), .Mode(Mode), .X(X),
    .pix_cnt(pix_cnt), .line_cnt(line_cnt), .frame_cnt(frame_cnt),
    .busy(busy), .cfg_err(cfg_err)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference model: frame position counted from the accepting edge
  bit running = 1'b0;
  bit stop_p = 1'b0;
  int pos = 0;
  int m_mode = 0, m_x = 0, m_fcnt = 0;
  int e_sync = 0, e_fsync = 0, e_endl = 0, e_endf = 0, e_pix = 0, e_line = 0;
  int e_busy = 0, e_cfg = 0, e_mode = 0, e_x = 0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      running = 1'b0; stop_p = 1'b0; pos = 0;
      m_mode = 0; m_x = 0; m_fcnt = 0; e_cfg = 0;
    end else begin
      e_cfg = 0;
      if (!running) begin
        if (start) begin
          if (mode_in != 0) begin
            running = 1'b1; pos = 0;
            m_mode = int'(mode_in); m_x = int'(x_in);
            stop_p = stop || !cont;
          end else begin
            e_cfg = 1;
          end
        end
      end else begin
        stop_p = stop_p || stop;
        if (pos == FR - 1) begin
          m_fcnt = (m_fcnt + 1) % 256;
          if (stop_p) begin
            running = 1'b0; stop_p = 1'b0;
          end else begin
            pos = 0; m_mode = int'(mode_in); m_x = int'(x_in);
          end
        end else begin
          pos++;
        end
      end
    end
    e_sync = 0; e_fsync = 0; e_endl = 0; e_endf = 0; e_pix = 0; e_line = 0;
    e_busy = 0; e_mode = 0; e_x = 0;
    if (running) begin
      int l, q;
      l = pos / LL;
      q = pos % LL;
      e_busy = 1; e_mode = m_mode; e_x = m_x;
      if (l < VA) begin
        e_line  = l;
        e_sync  = (q == 0) ? 1 : 0;
        e_fsync = (q == 0 && l == 0) ? 1 : 0;
        e_pix   = (q >= 1 && q <= HA) ? q - 1 : 0;
        e_endl  = (q > HA) ? 1 : 0;
      end else begin
        e_line = VA - 1; e_endl = 1; e_endf = 1;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  initial forever begin
    @(negedge clk);
    chk("m_sync",      32'(sync),      32'(e_sync));
    chk("m_f_sync",    32'(f_sync),    32'(e_fsync));
    chk("m_endLine",   32'(endLine),   32'(e_endl));
    chk("m_endFrame",  32'(endFrame),  32'(e_endf));
    chk("m_pix_cnt",   32'(pix_cnt),   32'(e_pix));
    chk("m_line_cnt",  32'(line_cnt),  32'(e_line));
    chk("m_frame_cnt", 32'(frame_cnt), 32'(m_fcnt));
    chk("m_busy",      32'(busy),      32'(e_busy));
    chk("m_cfg_err",   32'(cfg_err),   32'(e_cfg));
    chk("m_Mode",      32'(Mode),      32'(e_mode));
    chk("m_X",         32'(X),         32'(e_x));
  end

  initial begin
    cyc(2); rst_n = 1'b1; cyc(2);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_frame_cnt", 32'(frame_cnt), 0);

    // single frame
    start = 1; cont = 0; mode_in = 3; x_in = 1; cyc(1); start = 0;
    chk("sf_sync_c1", 32'(sync), 1);
    chk("sf_fsync_c1", 32'(f_sync), 1);
    chk("sf_busy_c1", 32'(busy), 1);
    chk("sf_mode_c1", 32'(Mode), 3);
    cyc(1); chk("sf_pix_c2", 32'(pix_cnt), 0); chk("sf_endl_c2", 32'(endLine), 0);
    cyc(3); chk("sf_pix_c5", 32'(pix_cnt), 3);
    cyc(1); chk("sf_endl_c6", 32'(endLine), 1);
    cyc(2); chk("sf_sync_c8", 32'(sync), 1); chk("sf_fsync_c8", 32'(f_sync), 0);
    chk("sf_line_c8", 32'(line_cnt), 1);
    cyc(7); chk("sf_sync_c15", 32'(sync), 1); chk("sf_line_c15", 32'(line_cnt), 2);
    cyc(6); chk("sf_endf_c21", 32'(endFrame), 0);
    cyc(1); chk("sf_endf_c22", 32'(endFrame), 1);
    cyc(6); chk("sf_endf_c28", 32'(endFrame), 1); chk("sf_mode_c28", 32'(Mode), 3);
    cyc(1); chk("sf_busy_c29", 32'(busy), 0); chk("sf_fcnt_c29", 32'(frame_cnt), 1);
    cyc(2);

    // invalid mode
    start = 1; cont = 1; mode_in = 0; cyc(1); start = 0;
    chk("inv_cfg_err", 32'(cfg_err), 1); chk("inv_busy", 32'(busy), 0);
    chk("inv_sync", 32'(sync), 0);
    cyc(1); chk("inv_cfg_err_c2", 32'(cfg_err), 0); chk("inv_busy_c2", 32'(busy), 0);

    // start while busy is ignored
    start = 1; cont = 0; mode_in = 5; cyc(1); start = 0;
    cyc(11); start = 1; mode_in = 1; cyc(1); start = 0;
    chk("swb_mode", 32'(Mode), 5);
    cyc(15); chk("swb_busy_c28", 32'(busy), 1);
    cyc(1); chk("swb_busy_c29", 32'(busy), 0); chk("swb_fcnt", 32'(frame_cnt), 2);
    cyc(2);

    // continuous with mid-frame stop
    start = 1; cont = 1; mode_in = 7; x_in = 2; cyc(1); start = 0;
    cyc(9); mode_in = 2;
    cyc(18); chk("cs_mode_c28", 32'(Mode), 7); chk("cs_endf_c28", 32'(endFrame), 1);
    cyc(1); chk("cs_fsync_c29", 32'(f_sync), 1); chk("cs_mode_c29", 32'(Mode), 2);
    chk("cs_x_c29", 32'(X), 2);
    cyc(11); stop = 1; cyc(1); stop = 0;
    cyc(15); chk("cs_busy_c56", 32'(busy), 1);
    cyc(1); chk("cs_busy_c57", 32'(busy), 0); chk("cs_fcnt", 32'(frame_cnt), 4);
    cyc(2);

    // stop on the last VBLANK edge
    start = 1; cont = 1; mode_in = 4; cyc(1); start = 0;
    cyc(27); stop = 1; chk("sb_endf_c28", 32'(endFrame), 1);
    cyc(1); stop = 0;
    chk("sb_busy_c29", 32'(busy), 0); chk("sb_fsync_c29", 32'(f_sync), 0);
    chk("sb_fcnt", 32'(frame_cnt), 5);
    cyc(7); chk("sb_busy_later", 32'(busy), 0);

    // async reset mid-frame
    start = 1; cont = 1; mode_in = 6; cyc(1); start = 0;
    cyc(16); chk("rm_pix_c17", 32'(pix_cnt), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rm_busy", 32'(busy), 0); chk("rm_pix", 32'(pix_cnt), 0);
    chk("rm_line", 32'(line_cnt), 0); chk("rm_fcnt", 32'(frame_cnt), 0);
    chk("rm_mode", 32'(Mode), 0);
    cyc(2); rst_n = 1'b1; cyc(1);
    start = 1; cont = 0; mode_in = 3; cyc(1); start = 0;
    chk("rm_fsync_after", 32'(f_sync), 1); chk("rm_busy_after", 32'(busy), 1);
    cyc(28); chk("rm_busy_end", 32'(busy), 0); chk("rm_fcnt_end", 32'(frame_cnt), 1);

    // frame counter wrap over 256 continuous frames
    rst_n = 1'b0; cyc(1); rst_n = 1'b1; cyc(1);
    start = 1; cont = 1; mode_in = 1; cyc(1); start = 0;
    cyc(256 * FR - 1);
    chk("wr_fcnt_255", 32'(frame_cnt), 255); chk("wr_endf", 32'(endFrame), 1);
    stop = 1; cyc(1); stop = 0;
    chk("wr_fcnt_0", 32'(frame_cnt), 0); chk("wr_busy", 32'(busy), 0);

    // randomized traffic checked by the model
    for (int i = 0; i < 3000; i++) begin
      start   = ($urandom_range(0, 7) == 0);
      stop    = ($urandom_range(0, 39) == 0);
      cont    = ($urandom_range(0, 3) != 0);
      mode_in = 3'($urandom_range(0, 7));
      x_in    = 2'($urandom_range(0, 3));
      cyc(1);
    end
    start = 0; stop = 0;
    cyc(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
